// File: rtl/io_clk_transmitter_if.sv
// Word-source handshake into the IO clock transmitter.
// The master drives data_valid and data, and the slave answers with data_ready.
interface io_clk_transmitter_if #(
    parameter int unsigned Data_Width = 8
);
    logic                  data_valid;
    logic [Data_Width-1:0] data;
    logic                  data_ready;

    modport master (
        output data_valid,
        output data,
        input  data_ready
    );

    modport slave (
        input  data_valid,
        input  data,
        output data_ready
    );
endinterface

// File: rtl/io_clk_transmitter.sv
// Transmit end of the source-synchronous IO clock interface. It divides clk_i into
// io_clk_o and launches one word per period on the falling edge, with low-held pauses.
module io_clk_transmitter #(
    parameter int unsigned Half_Period_Width   = 8,
    parameter int unsigned Data_Width          = 8,
    parameter int unsigned Short_Pause_Periods = 2,
    parameter int unsigned Long_Pause_Periods  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         enable_i,
    input  logic [Half_Period_Width-1:0] half_period_i,
    input  logic                         pause_req_i,
    input  logic                         pause_long_i,
    io_clk_transmitter_if.slave          src_if,
    output logic                         io_clk_o,
    output logic [Data_Width-1:0]        io_data_o,
    output logic                         clk_lock_o,
    output logic                         short_pause_complete_o,
    output logic                         long_pause_complete_o
);

    localparam int unsigned PCNT_W =
        $clog2(2 * Long_Pause_Periods * (2 ** Half_Period_Width));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [Half_Period_Width-1:0] h_q, h_d;
    logic [Half_Period_Width-1:0] hcnt_q, hcnt_d;
    logic [PCNT_W-1:0]        pcnt_q, pcnt_d;
    logic                     clk_q, clk_d;
    logic [Data_Width-1:0]    data_q, data_d;
    logic                     lock_q, lock_d;
    logic                     long_q, long_d;
    logic                     pre_q, pre_d;
    logic                     spc_q, spc_d;
    logic                     lpc_q, lpc_d;

    logic                     h_last_c;
    logic                     launch_c;
    logic                     permit_c;
    logic [PCNT_W-1:0]        pause_len_c;
    logic [PCNT_W-1:0]        term_c;
    logic                     at_term_c;
    logic                     ready_c;
    logic                     xfer_c;

    // Shared decode: launch points, pause terminal and the handshake
    assign h_last_c    = (hcnt_q == h_q - Half_Period_Width'(1));
    assign launch_c    = (state_q == RUN) && h_last_c && clk_q;
    assign permit_c    = enable_i && !pause_req_i;
    assign pause_len_c = long_q ? PCNT_W'(2 * Long_Pause_Periods)
                                : PCNT_W'(2 * Short_Pause_Periods);
    assign term_c      = pause_len_c * PCNT_W'(h_q) - PCNT_W'(1);
    assign at_term_c   = (pcnt_q == term_c);
    assign xfer_c      = ready_c && src_if.data_valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_i) state_d = PAUSE;
            end
            PAUSE: begin
                if (!enable_i)   state_d = IDLE;
                else if (xfer_c) state_d = RUN;
            end
            RUN: begin
                if (launch_c && !xfer_c) state_d = enable_i ? PAUSE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values and the combinational ready
    always_comb begin
        ready_c = 1'b0;
        h_d     = h_q;
        hcnt_d  = hcnt_q;
        pcnt_d  = pcnt_q;
        clk_d   = clk_q;
        data_d  = data_q;
        lock_d  = lock_q;
        long_d  = long_q;
        pre_d   = pre_q;
        spc_d   = 1'b0;
        lpc_d   = 1'b0;
        case (state_q)
            IDLE: begin
                clk_d  = 1'b0;
                lock_d = 1'b0;
                if (enable_i) begin
                    h_d    = (half_period_i == '0) ? Half_Period_Width'(1) : half_period_i;
                    long_d = 1'b1;
                    pre_d  = 1'b1;
                    pcnt_d = '0;
                end
            end
            PAUSE: begin
                clk_d   = 1'b0;
                ready_c = permit_c && at_term_c && lock_q;
                if (!enable_i) begin
                    lock_d = 1'b0;
                    pcnt_d = '0;
                end else if (xfer_c) begin
                    data_d = src_if.data;
                    hcnt_d = '0;
                    pre_d  = 1'b0;
                end else begin
                    if (!at_term_c) pcnt_d = pcnt_q + PCNT_W'(1);
                    // Pulse lands in the terminal cycle itself
                    if (pcnt_q == term_c - PCNT_W'(1)) begin
                        spc_d = !long_q;
                        lpc_d = long_q;
                    end
                    if (pre_q && at_term_c) lock_d = 1'b1;
                end
            end
            RUN: begin
                ready_c = launch_c && permit_c;
                if (h_last_c) begin
                    hcnt_d = '0;
                    clk_d  = !clk_q;
                    if (clk_q) begin
                        if (xfer_c) begin
                            data_d = src_if.data;
                        end else begin
                            long_d = pause_long_i;
                            pre_d  = 1'b0;
                            pcnt_d = '0;
                            if (!enable_i) lock_d = 1'b0;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + Half_Period_Width'(1);
                end
            end
            default: begin
                clk_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_q    <= Half_Period_Width'(1);
            hcnt_q <= '0;
            pcnt_q <= '0;
            clk_q  <= 1'b0;
            data_q <= '0;
            lock_q <= 1'b0;
            long_q <= 1'b1;
            pre_q  <= 1'b0;
            spc_q  <= 1'b0;
            lpc_q  <= 1'b0;
        end else begin
            h_q    <= h_d;
            hcnt_q <= hcnt_d;
            pcnt_q <= pcnt_d;
            clk_q  <= clk_d;
            data_q <= data_d;
            lock_q <= lock_d;
            long_q <= long_d;
            pre_q  <= pre_d;
            spc_q  <= spc_d;
            lpc_q  <= lpc_d;
        end
    end

    assign src_if.data_ready      = ready_c;
    assign io_clk_o               = clk_q;
    assign io_data_o              = data_q;
    assign clk_lock_o             = lock_q;
    assign short_pause_complete_o = spc_q;
    assign long_pause_complete_o  = lpc_q;

endmodule

// File: tb/tb_io_clk_transmitter.sv
// Bench for io_clk_transmitter: directed scenarios plus random traffic checked
// cycle by cycle against a time-based behavioural model.
module tb_io_clk_transmitter;

    localparam int unsigned HPW     = 8;
    localparam int unsigned DW      = 8;
    localparam int unsigned SHORT_N = 2;
    localparam int unsigned LONG_N  = 8;
    localparam int M_IDLE  = 0;
    localparam int M_PAUSE = 1;
    localparam int M_RUN   = 2;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           en    = 1'b0;
    logic           req   = 1'b0;
    logic           pl    = 1'b0;
    logic [HPW-1:0] hp    = '0;
    logic           io_clk;
    logic [DW-1:0]  io_data;
    logic           lock, spc, lpc;

    io_clk_transmitter_if #(.Data_Width(DW)) src_if ();

    io_clk_transmitter #(
        .Half_Period_Width  (HPW),
        .Data_Width         (DW),
        .Short_Pause_Periods(SHORT_N),
        .Long_Pause_Periods (LONG_N)
    ) dut (
        .clk_i                 (clk),
        .rst_n_i               (rst_n),
        .enable_i              (en),
        .half_period_i         (hp),
        .pause_req_i           (req),
        .pause_long_i          (pl),
        .src_if                (src_if.slave),
        .io_clk_o              (io_clk),
        .io_data_o             (io_data),
        .clk_lock_o            (lock),
        .short_pause_complete_o(spc),
        .long_pause_complete_o (lpc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Model: state plus elapsed cycles in that state; waveform follows from arithmetic
    int          m_state = M_IDLE;
    int          m_t     = 0;
    int          m_h     = 1;
    bit          m_long  = 1'b1;
    bit          m_pre   = 1'b0;
    bit          m_lock  = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] src_word = 8'h11;
    bit          rand_words = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_t     = 0;
        m_h     = 1;
        m_long  = 1'b1;
        m_pre   = 1'b0;
        m_lock  = 1'b0;
        m_data  = '0;
    endtask

    // One system cycle: drive at negedge, check, advance model, wait for next negedge
    task automatic tick(input bit e, input bit r, input bit p, input bit v);
        logic [12:0] exp_v, obs_v;
        bit clk_e, launch_e, spc_e, lpc_e, rdy_e, xfer;
        int ph, term;
        en = e; req = r; pl = p;
        src_if.data_valid = v;
        src_if.data       = src_word;
        #1;
        term     = 2 * (m_long ? LONG_N : SHORT_N) * m_h - 1;
        ph       = (m_state == M_RUN) ? (m_t % (2 * m_h)) : 0;
        clk_e    = (m_state == M_RUN) && (ph >= m_h);
        launch_e = (m_state == M_RUN) && (ph == 2 * m_h - 1);
        spc_e    = (m_state == M_PAUSE) && !m_long && (m_t == term);
        lpc_e    = (m_state == M_PAUSE) && m_long && (m_t == term);
        rdy_e    = e && !r && (launch_e || ((m_state == M_PAUSE) && (m_t >= term) && m_lock));
        exp_v = {clk_e, m_lock, spc_e, lpc_e, rdy_e, m_data};
        obs_v = {io_clk, lock, spc, lpc, src_if.data_ready, io_data};
        check_eq("outs", 32'(obs_v), 32'(exp_v));
        xfer = rdy_e && v;
        case (m_state)
            M_IDLE: if (e) begin
                m_state = M_PAUSE; m_t = 0; m_long = 1'b1; m_pre = 1'b1;
                m_h = (hp == 0) ? 1 : int'(hp);
            end
            M_PAUSE: begin
                if (!e) begin
                    m_state = M_IDLE; m_lock = 1'b0;
                end else if (xfer) begin
                    m_state = M_RUN; m_t = 0; m_data = src_word; m_pre = 1'b0;
                end else begin
                    if (m_pre && m_t >= term) m_lock = 1'b1;
                    m_t++;
                end
            end
            default: begin
                if (launch_e && !xfer) begin
                    m_long = p; m_pre = 1'b0; m_t = 0;
                    if (e) m_state = M_PAUSE;
                    else begin m_state = M_IDLE; m_lock = 1'b0; end
                end else begin
                    if (xfer) m_data = src_word;
                    m_t++;
                end
            end
        endcase
        if (xfer) src_word = rand_words ? DW'($urandom) : src_word + 8'h11;
        @(negedge clk);
    endtask

    initial begin
        int first, cnt, lowrun, maxlow, hi, guard;
        bit e_r;
        src_if.data_valid = 1'b0;
        src_if.data       = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_clk", 32'(io_clk), 0);
        check_eq("rst_data", 32'(io_data), 0);
        check_eq("rst_lock", 32'(lock), 0);
        check_eq("rst_pulses", 32'({spc, lpc}), 0);
        check_eq("rst_ready", 32'(src_if.data_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Preamble with H=2: long pulse at pause cycle 31
        hp = 8'd2;
        first = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1, 0, 0, 0);
            if (lpc && first < 0) first = i;
        end
        check_eq("preamble_pulse_cycle", 32'(first), 32'd31);

        // Short pause: one missed launch point, low run of 2NH+H = 10
        for (int i = 0; i < 12; i++) tick(1, 0, 0, 1);
        maxlow = 0; lowrun = 0; cnt = 0;
        for (int i = 0; i < 28; i++) begin
            tick(1, 0, 0, (i >= 4));
            lowrun = io_clk ? 0 : lowrun + 1;
            if (lowrun > maxlow) maxlow = lowrun;
            if (spc) cnt++;
        end
        check_eq("short_low_run", 32'(maxlow), 32'd10);
        check_eq("short_pulse_count", 32'(cnt), 32'd1);

        // Pause request beats valid; ready never rises while requested
        cnt = 0; hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1, 1, 1, 1);
            if (src_if.data_ready) cnt++;
            if (lpc) hi++;
        end
        check_eq("priority_ready_count", 32'(cnt), 0);
        check_eq("priority_long_pulses", 32'(hi), 32'd1);
        for (int i = 0; i < 16; i++) tick(1, 0, 0, 1);

        // Disable, then re-enable with H=4 and drop enable on the first high cycle
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 1);
        check_eq("disable_lock", 32'(lock), 0);
        hp = 8'd4;
        for (int i = 0; i < 70; i++) tick(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 1);
        guard = 0;
        while (!(m_state == M_RUN && (m_t % 8) == 4) && guard < 50) begin
            tick(1, 0, 0, 1);
            guard++;
        end
        check_eq("disable_align_timeout", 32'(guard < 50), 32'd1);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (io_clk) hi++;
            tick(0, 0, 0, 1);
        end
        check_eq("disable_high_len", 32'(hi), 32'd4);
        check_eq("disable_idle_lock", 32'(lock), 0);

        // Re-enable with H=3, stream 0x11, 0x22, 0x33 ...
        hp = 8'd3;
        src_word = 8'h11;
        for (int i = 0; i < 60; i++) tick(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) tick(1, 0, 0, 1);

        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_clk", 32'(io_clk), 0);
        check_eq("async_rst_data", 32'(io_data), 0);
        check_eq("async_rst_lock", 32'(lock), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // H=0 acts as H=1
        hp = 8'd0;
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 0, 1);
            if (io_clk) cnt++;
        end
        check_eq("h0_high_cycles", 32'(cnt), 32'd10);

        // Random traffic
        rand_words = 1'b1;
        e_r = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) e_r = !e_r;
            hp = HPW'($urandom_range(0, 4));
            tick(e_r, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
